// File: rtl/id_ex_stage_if.sv
// ID -> ID/EX pipeline bus: decoded instruction and flush in; registered
// ALU/memory controls, load-use stall and bubble counter out.
interface id_ex_stage_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] rs_data_id;
    logic [DATA_W-1:0] rt_data_id;
    logic [DATA_W-1:0] signextend_id;
    logic [4:0]        rs_addr_id;
    logic [4:0]        rt_addr_id;
    logic [4:0]        rd_addr_id;
    logic [3:0]        alu_control_id;
    logic              alu_src_id;
    logic              reg_dst_id;
    logic              mem_read_id;
    logic              mem_write_id;
    logic              mem_to_reg_id;
    logic              reg_write_id;
    logic              uses_rt_id;
    logic              valid_id;
    logic              flush;

    logic [DATA_W-1:0] rs_data_idex;
    logic [DATA_W-1:0] rt_data_idex;
    logic [DATA_W-1:0] signextend_idex;
    logic [3:0]        alu_control_idex;
    logic              alu_src_idex;
    logic [4:0]        rs_addr_idex;
    logic [4:0]        rt_addr_idex;
    logic [4:0]        write_reg_idex;
    logic              mem_read_idex;
    logic              mem_write_idex;
    logic              mem_to_reg_idex;
    logic              reg_write_idex;
    logic              valid_idex;
    logic              stall;
    logic [15:0]       bubble_count;

    modport master (
        output rs_data_id, rt_data_id, signextend_id, rs_addr_id, rt_addr_id, rd_addr_id,
               alu_control_id, alu_src_id, reg_dst_id, mem_read_id, mem_write_id,
               mem_to_reg_id, reg_write_id, uses_rt_id, valid_id, flush,
        input  rs_data_idex, rt_data_idex, signextend_idex, alu_control_idex, alu_src_idex,
               rs_addr_idex, rt_addr_idex, write_reg_idex, mem_read_idex, mem_write_idex,
               mem_to_reg_idex, reg_write_idex, valid_idex, stall, bubble_count
    );

    modport slave (
        input  rs_data_id, rt_data_id, signextend_id, rs_addr_id, rt_addr_id, rd_addr_id,
               alu_control_id, alu_src_id, reg_dst_id, mem_read_id, mem_write_id,
               mem_to_reg_id, reg_write_id, uses_rt_id, valid_id, flush,
        output rs_data_idex, rt_data_idex, signextend_idex, alu_control_idex, alu_src_idex,
               rs_addr_idex, rt_addr_idex, write_reg_idex, mem_read_idex, mem_write_idex,
               mem_to_reg_idex, reg_write_idex, valid_idex, stall, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// on stall/flush/empty slot, and a saturating count of stall bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs_addr;
        logic [4:0]        rt_addr;
        logic [4:0]        write_reg;
        logic [3:0]        alu_control;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic              valid;
    } idex_t;

    idex_t       idex_q, idex_d, bubble_val, load_val;
    logic [15:0] bubble_count_q, bubble_count_d;
    logic [4:0]  write_reg;
    logic        hazard, stall, insert_bubble;

    always_comb begin
        bubble_val             = '0;
        bubble_val.alu_control = 4'b0010;

        write_reg = bus.reg_dst_id ? bus.rd_addr_id : bus.rt_addr_id;

        load_val             = '0;
        load_val.rs_data     = bus.rs_data_id;
        load_val.rt_data     = bus.rt_data_id;
        load_val.imm         = bus.signextend_id;
        load_val.rs_addr     = bus.rs_addr_id;
        load_val.rt_addr     = bus.rt_addr_id;
        load_val.write_reg   = write_reg;
        load_val.alu_control = bus.alu_control_id;
        load_val.alu_src     = bus.alu_src_id;
        load_val.mem_read    = bus.mem_read_id & bus.valid_id;
        load_val.mem_write   = bus.mem_write_id & bus.valid_id;
        load_val.mem_to_reg  = bus.mem_to_reg_id & bus.valid_id;
        // r0 is hardwired zero, so a write to it is dropped here once
        load_val.reg_write   = bus.reg_write_id & bus.valid_id & (write_reg != 5'd0);
        load_val.valid       = bus.valid_id;

        hazard = idex_q.valid & idex_q.mem_read & (idex_q.rt_addr != 5'd0) & bus.valid_id &
                 ((idex_q.rt_addr == bus.rs_addr_id) |
                  (bus.uses_rt_id & (idex_q.rt_addr == bus.rt_addr_id)));
        stall         = hazard & ~bus.flush & ~rst;
        insert_bubble = stall | bus.flush | ~bus.valid_id;
        idex_d        = insert_bubble ? bubble_val : load_val;

        bubble_count_d = bubble_count_q;
        if (stall && (bubble_count_q != 16'hFFFF)) begin
            bubble_count_d = bubble_count_q + 16'd1;
        end
    end

    // Reset value equals the bubble pattern (alu_control = add).
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q         <= bubble_val;
            bubble_count_q <= 16'd0;
        end else begin
            idex_q         <= idex_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bus.rs_data_idex     = idex_q.rs_data;
    assign bus.rt_data_idex     = idex_q.rt_data;
    assign bus.signextend_idex  = idex_q.imm;
    assign bus.alu_control_idex = idex_q.alu_control;
    assign bus.alu_src_idex     = idex_q.alu_src;
    assign bus.rs_addr_idex     = idex_q.rs_addr;
    assign bus.rt_addr_idex     = idex_q.rt_addr;
    assign bus.write_reg_idex   = idex_q.write_reg;
    assign bus.mem_read_idex    = idex_q.mem_read;
    assign bus.mem_write_idex   = idex_q.mem_write;
    assign bus.mem_to_reg_idex  = idex_q.mem_to_reg;
    assign bus.reg_write_idex   = idex_q.reg_write;
    assign bus.valid_idex       = idex_q.valid;
    assign bus.stall            = stall;
    assign bus.bubble_count     = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: table of per-cycle instructions with
// hand-computed stall/ID-EX contents, plus reset-mid-stall and saturation runs.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(32)) bus ();

    id_ex_stage #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd;
        logic [3:0]  alu;
        logic        reg_dst, mr, rw, uses_rt, flush;
    } vin_t;

    typedef struct {
        logic        stall, valid, rw, mr;
        logic [4:0]  wr;
        logic [3:0]  alu;
        logic [31:0] rsd, rtd;
        logic [15:0] cnt;
    } vexp_t;

    typedef struct {
        vin_t  i;
        vexp_t e;
    } vec_t;

    vec_t vecs[17];

    function automatic vin_t vi(logic valid, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic [31:0] rsd, logic [31:0] rtd, logic [3:0] alu,
                                logic reg_dst, logic mr, logic rw, logic uses_rt, logic flush);
        vin_t v;
        v.valid = valid; v.rs = rs; v.rt = rt; v.rd = rd; v.rsd = rsd; v.rtd = rtd;
        v.alu = alu; v.reg_dst = reg_dst; v.mr = mr; v.rw = rw; v.uses_rt = uses_rt;
        v.flush = flush;
        return v;
    endfunction

    function automatic vexp_t ve(logic stall, logic valid, logic rw, logic mr, logic [4:0] wr,
                                 logic [3:0] alu, logic [31:0] rsd, logic [31:0] rtd,
                                 logic [15:0] cnt);
        vexp_t e;
        e.stall = stall; e.valid = valid; e.rw = rw; e.mr = mr; e.wr = wr; e.alu = alu;
        e.rsd = rsd; e.rtd = rtd; e.cnt = cnt;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vin_t v);
        bus.valid_id       = v.valid;
        bus.rs_addr_id     = v.rs;
        bus.rt_addr_id     = v.rt;
        bus.rd_addr_id     = v.rd;
        bus.rs_data_id     = v.rsd;
        bus.rt_data_id     = v.rtd;
        bus.signextend_id  = v.rsd + 32'd4;
        bus.alu_control_id = v.alu;
        bus.alu_src_id     = v.mr;
        bus.reg_dst_id     = v.reg_dst;
        bus.mem_read_id    = v.mr;
        bus.mem_write_id   = 1'b0;
        bus.mem_to_reg_id  = v.mr;
        bus.reg_write_id   = v.rw;
        bus.uses_rt_id     = v.uses_rt;
        bus.flush          = v.flush;
    endtask

    task automatic chk_state(input string tag, input vexp_t e);
        chk({tag, ".valid"},   {31'd0, bus.valid_idex},      {31'd0, e.valid});
        chk({tag, ".rw"},      {31'd0, bus.reg_write_idex},  {31'd0, e.rw});
        chk({tag, ".mr"},      {31'd0, bus.mem_read_idex},   {31'd0, e.mr});
        chk({tag, ".mtr"},     {31'd0, bus.mem_to_reg_idex}, {31'd0, e.mr});
        chk({tag, ".wr"},      {27'd0, bus.write_reg_idex},  {27'd0, e.wr});
        chk({tag, ".alu"},     {28'd0, bus.alu_control_idex}, {28'd0, e.alu});
        chk({tag, ".rsd"},     bus.rs_data_idex,             e.rsd);
        chk({tag, ".rtd"},     bus.rt_data_idex,             e.rtd);
        chk({tag, ".cnt"},     {16'd0, bus.bubble_count},    {16'd0, e.cnt});
    endtask

    vin_t  idle_in, lw9, use9, lw13, use13;

    initial begin
        // in: valid rs rt rd rsd rtd alu reg_dst mr rw uses_rt flush
        // exp: stall | valid rw mr wr alu rsd rtd cnt (after the edge)
        vecs[0]  = '{vi(1,3,4,8,5,7,4'b0010,1,0,1,1,0),            ve(0,1,1,0,8,4'b0010,5,7,0)};
        vecs[1]  = '{vi(1,3,9,0,100,0,4'b0010,0,1,1,0,0),          ve(0,1,1,1,9,4'b0010,100,0,0)};
        vecs[2]  = '{vi(1,9,5,10,'h11,'h22,4'b0110,1,0,1,1,0),     ve(1,0,0,0,0,4'b0010,0,0,1)};
        vecs[3]  = '{vi(1,9,5,10,'h11,'h22,4'b0110,1,0,1,1,0),     ve(0,1,1,0,10,4'b0110,'h11,'h22,1)};
        vecs[4]  = '{vi(1,2,0,0,8,0,4'b0010,0,1,1,0,0),            ve(0,1,0,1,0,4'b0010,8,0,1)};
        vecs[5]  = '{vi(1,0,0,0,3,4,4'b0001,0,0,1,1,0),            ve(0,1,0,0,0,4'b0001,3,4,1)};
        vecs[6]  = '{vi(1,1,7,0,'h40,0,4'b0010,0,1,1,0,0),         ve(0,1,1,1,7,4'b0010,'h40,0,1)};
        vecs[7]  = '{vi(1,1,7,3,'h41,'h42,4'b0000,1,0,1,1,1),      ve(0,0,0,0,0,4'b0010,0,0,1)};
        vecs[8]  = '{vi(1,1,12,0,'h80,0,4'b0010,0,1,1,0,0),        ve(0,1,1,1,12,4'b0010,'h80,0,1)};
        vecs[9]  = '{vi(1,2,12,0,'h90,'h91,4'b0010,0,0,1,0,0),     ve(0,1,1,0,12,4'b0010,'h90,'h91,1)};
        vecs[10] = '{vi(1,1,5,0,'h50,0,4'b0010,0,1,1,0,0),         ve(0,1,1,1,5,4'b0010,'h50,0,1)};
        vecs[11] = '{vi(0,5,5,6,'h55,'h56,4'b0111,1,1,1,1,0),      ve(0,0,0,0,0,4'b0010,0,0,1)};
        vecs[12] = '{vi(1,1,5,0,'h51,0,4'b0010,0,1,1,0,0),         ve(0,1,1,1,5,4'b0010,'h51,0,1)};
        vecs[13] = '{vi(1,5,6,0,'h60,0,4'b0010,0,1,1,0,0),         ve(1,0,0,0,0,4'b0010,0,0,2)};
        vecs[14] = '{vi(1,5,6,0,'h60,0,4'b0010,0,1,1,0,0),         ve(0,1,1,1,6,4'b0010,'h60,0,2)};
        vecs[15] = '{vi(1,2,6,11,'h70,'h71,4'b0110,1,0,1,1,0),     ve(1,0,0,0,0,4'b0010,0,0,3)};
        vecs[16] = '{vi(1,2,6,11,'h70,'h71,4'b0110,1,0,1,1,0),     ve(0,1,1,0,11,4'b0110,'h70,'h71,3)};

        idle_in = vi(0,0,0,0,0,0,4'b0000,0,0,0,0,0);
        lw9     = vi(1,1,9,0,'hA0,0,4'b0010,0,1,1,0,0);
        use9    = vi(1,9,3,4,'hB0,'hB1,4'b0110,1,0,1,1,0);
        lw13    = vi(1,1,13,0,'hC0,0,4'b0010,0,1,1,0,0);
        use13   = vi(1,13,2,14,'hD0,'hD1,4'b0110,1,0,1,1,0);

        // Reset with a load-use pattern on the ID side: no stall, reset state.
        drive(use9);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", {31'd0, bus.stall}, 32'd0);
        chk_state("rst", ve(0,0,0,0,0,4'b0010,0,0,0));
        $display("reset: stall=%0b cnt=%0d alu=%b", bus.stall, bus.bubble_count, bus.alu_control_idex);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].i);
            #1;
            chk($sformatf("v%0d.stall", i), {31'd0, bus.stall}, {31'd0, vecs[i].e.stall});
            @(posedge clk);
            #1;
            chk_state($sformatf("v%0d", i), vecs[i].e);
            $display("vec %0d: stall_exp=%0b valid=%0b rw=%0b mr=%0b wr=%0d cnt=%0d", i,
                     vecs[i].e.stall, bus.valid_idex, bus.reg_write_idex, bus.mem_read_idex,
                     bus.write_reg_idex, bus.bubble_count);
        end

        // Reset asserted while a load-use stall is active.
        @(negedge clk); drive(lw13);
        @(negedge clk); drive(use13);
        #1;
        chk("rmid.stall_pre", {31'd0, bus.stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rmid.stall_rst", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        chk_state("rmid", ve(0,0,0,0,0,4'b0010,0,0,0));
        @(negedge clk);
        chk("rmid.stall_hold", {31'd0, bus.stall}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rmid.stall_rel", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        chk_state("rmid.load", ve(0,1,1,0,14,4'b0110,'hD0,'hD1,0));
        $display("reset mid-stall: cnt=%0d valid=%0b wr=%0d", bus.bubble_count, bus.valid_idex,
                 bus.write_reg_idex);

        // Saturation: preload counter to FFFE, then two more load-use stalls.
        @(negedge clk);
        drive(idle_in);
        force dut.bubble_count_q = 16'hFFFE;
        #1;
        release dut.bubble_count_q;
        #1;
        chk("sat.preload", {16'd0, bus.bubble_count}, 32'h0000FFFE);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); drive(lw9);
            @(negedge clk); drive(use9);
            #1;
            chk($sformatf("sat%0d.stall", k), {31'd0, bus.stall}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.cnt", k), {16'd0, bus.bubble_count}, 32'h0000FFFF);
            @(negedge clk);
            #1;
            chk($sformatf("sat%0d.stall_after", k), {31'd0, bus.stall}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.cnt_after", k), {16'd0, bus.bubble_count}, 32'h0000FFFF);
            $display("saturation %0d: cnt=%0h", k, bus.bubble_count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
